// File: rtl/mmio_pkg.sv
// Shared types and helpers for the AXI4-Lite MMIO register file.
// Response codes, channel FSM states and the byte-strobe merge.
package mmio_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  // Widest bus is 64 bits; callers cast to and from their own width.
  function automatic logic [63:0] strb_merge(
    input logic [63:0] old_v,
    input logic [63:0] upd_v,
    input logic [7:0]  strb
  );
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[b*8 +: 8] = strb[b] ? upd_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_axil_wr_join.sv
// AXI4-Lite AW/W capture and join; emits a one-cycle commit strobe.
// Owns the B channel: the response is latched from i_cmt_err at commit.
module mmio_axil_wr_join
  import mmio_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [1:0]              o_bresp,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  output logic                    o_commit,
  output logic [ADDR_WIDTH-1:0]   o_cmt_addr,
  output logic [DATA_WIDTH-1:0]   o_cmt_data,
  output logic [DATA_WIDTH/8-1:0] o_cmt_strb,
  input  logic                    i_cmt_err
);

  wr_state_t r_state;
  wr_state_t w_state_nxt;

  logic                    r_aw_got;
  logic                    r_w_got;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [DATA_WIDTH/8-1:0] r_strb;
  logic [1:0]              r_bresp;
  logic                    w_aw_hs;
  logic                    w_w_hs;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= W_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Readies are forced low while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    o_awready   = 1'b0;
    o_wready    = 1'b0;
    o_commit    = 1'b0;
    unique case (r_state)
      W_IDLE: begin
        o_awready = ~i_rst;
        o_wready  = ~i_rst;
        if (i_awvalid || i_wvalid) begin
          w_state_nxt = W_WAIT;
        end
      end
      W_WAIT: begin
        o_awready = ~i_rst & ~r_aw_got;
        o_wready  = ~i_rst & ~r_w_got;
        if (r_aw_got && r_w_got) begin
          o_commit    = 1'b1;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (i_bready) begin
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign w_aw_hs = o_awready & i_awvalid;
  assign w_w_hs  = o_wready & i_wvalid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_strb   <= '0;
      r_bresp  <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_got <= 1'b1;
        r_addr   <= i_awaddr;
      end
      if (w_w_hs) begin
        r_w_got <= 1'b1;
        r_data  <= i_wdata;
        r_strb  <= i_wstrb;
      end
      if (o_commit) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
        r_bresp  <= i_cmt_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign o_bvalid   = (r_state == W_RESP);
  assign o_bresp    = r_bresp;
  assign o_cmt_addr = r_addr;
  assign o_cmt_data = r_data;
  assign o_cmt_strb = r_strb;

endmodule

// File: rtl/mmio_regfile_axil.sv
// Parametrised AXI4-Lite register file with RO status slots and write pulses.
// Optional sticky interrupts (PENDING/ENABLE slots) under `MMIO_IRQ_EN.
module mmio_regfile_axil
  import mmio_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RST_VAL = '0,
  parameter int NUM_IRQ    = 4
) (
  input  logic                           s00_axi_aclk,
  input  logic                           s00_axi_areset,
  input  logic [ADDR_WIDTH-1:0]          s00_axi_awaddr,
  input  logic [2:0]                     s00_axi_awprot,
  input  logic                           s00_axi_awvalid,
  output logic                           s00_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s00_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s00_axi_wstrb,
  input  logic                           s00_axi_wvalid,
  output logic                           s00_axi_wready,
  output logic [1:0]                     s00_axi_bresp,
  output logic                           s00_axi_bvalid,
  input  logic                           s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s00_axi_araddr,
  input  logic [2:0]                     s00_axi_arprot,
  input  logic                           s00_axi_arvalid,
  output logic                           s00_axi_arready,
  output logic [DATA_WIDTH-1:0]          s00_axi_rdata,
  output logic [1:0]                     s00_axi_rresp,
  output logic                           s00_axi_rvalid,
  input  logic                           s00_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_d,
  input  logic [NUM_IRQ-1:0]             irq_in,
  output logic                           irq
);

  localparam int SW  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(SW);
  localparam int IW  = ADDR_WIDTH - OFF;

  logic                  clk;
  logic                  rst;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_merged [NUM_REGS];
  logic [NUM_REGS-1:0]   r_wr_pulse;
  logic [NUM_REGS-1:0]   w_pulse;

  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_cmt_addr;
  logic [DATA_WIDTH-1:0] w_cmt_data;
  logic [SW-1:0]         w_cmt_strb;
  logic                  w_werr;
  logic [IW-1:0]         w_widx;
  logic [IW-1:0]         w_ridx;

  rd_state_t             r_rstate;
  rd_state_t             w_rstate_nxt;
  logic                  w_ar_hs;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_rerr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  w_unused;

  assign clk    = s00_axi_aclk;
  assign rst    = s00_axi_areset;
  assign w_widx = w_cmt_addr[ADDR_WIDTH-1:OFF];
  assign w_ridx = s00_axi_araddr[ADDR_WIDTH-1:OFF];

`ifdef MMIO_IRQ_EN
  localparam logic [IW-1:0] NR_PEND = IW'(NUM_REGS);
  localparam logic [IW-1:0] NR_EN   = IW'(NUM_REGS + 1);

  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_en;
  logic [NUM_IRQ-1:0] w_pend_nxt;
  logic [NUM_IRQ-1:0] w_en_nxt;
  logic [NUM_IRQ-1:0] w_clr;
  logic               r_irq;
`endif

  mmio_axil_wr_join #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_join (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_awaddr   (s00_axi_awaddr),
    .i_awvalid  (s00_axi_awvalid),
    .o_awready  (s00_axi_awready),
    .i_wdata    (s00_axi_wdata),
    .i_wstrb    (s00_axi_wstrb),
    .i_wvalid   (s00_axi_wvalid),
    .o_wready   (s00_axi_wready),
    .o_bresp    (s00_axi_bresp),
    .o_bvalid   (s00_axi_bvalid),
    .i_bready   (s00_axi_bready),
    .o_commit   (w_commit),
    .o_cmt_addr (w_cmt_addr),
    .o_cmt_data (w_cmt_data),
    .o_cmt_strb (w_cmt_strb),
    .i_cmt_err  (w_werr)
  );

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_merged[i] = DATA_WIDTH'(strb_merge(
        64'(r_regs[i]), 64'(w_cmt_data), 8'(w_cmt_strb)));
    end
  end

  // RO slots answer SLVERR on write but never change or pulse.
  always_comb begin
    w_werr  = 1'b1;
    w_pulse = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_widx == IW'(i)) begin
        w_werr     = RO_MASK[i];
        w_pulse[i] = w_commit & ~RO_MASK[i] & (|w_cmt_strb);
      end
    end
`ifdef MMIO_IRQ_EN
    if (w_widx == NR_PEND || w_widx == NR_EN) begin
      w_werr = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RST_VAL[i*DATA_WIDTH +: DATA_WIDTH];
      end
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_pulse;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_pulse[i]) begin
          r_regs[i] <= w_merged[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

  assign reg_wr_pulse = r_wr_pulse;

`ifdef MMIO_IRQ_EN
  // Set beats a same-cycle W1C; irq follows next-state values.
  always_comb begin
    w_clr    = '0;
    w_en_nxt = r_en;
    if (w_commit && w_widx == NR_PEND) begin
      w_clr = NUM_IRQ'(strb_merge(
        64'(0), 64'(w_cmt_data), 8'(w_cmt_strb)));
    end
    if (w_commit && w_widx == NR_EN) begin
      w_en_nxt = NUM_IRQ'(strb_merge(
        64'(r_en), 64'(w_cmt_data), 8'(w_cmt_strb)));
    end
    w_pend_nxt = (r_pend & ~w_clr) | irq_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_en   <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_en   <= w_en_nxt;
      r_irq  <= |(w_pend_nxt & w_en_nxt);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate <= R_IDLE;
    end else begin
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    unique case (r_rstate)
      R_IDLE: if (w_ar_hs) w_rstate_nxt = R_RESP;
      R_RESP: if (s00_axi_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign s00_axi_arready = (r_rstate == R_IDLE) & ~rst;
  assign s00_axi_rvalid  = (r_rstate == R_RESP);
  assign w_ar_hs         = s00_axi_arready & s00_axi_arvalid;

  // Registers are sampled before any same-edge commit lands.
  always_comb begin
    w_rdata = '0;
    w_rerr  = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ridx == IW'(i)) begin
        w_rerr  = 1'b0;
        w_rdata = RO_MASK[i] ?
          ro_d[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
      end
    end
`ifdef MMIO_IRQ_EN
    if (w_ridx == NR_PEND) begin
      w_rerr  = 1'b0;
      w_rdata = DATA_WIDTH'(r_pend);
    end
    if (w_ridx == NR_EN) begin
      w_rerr  = 1'b0;
      w_rdata = DATA_WIDTH'(r_en);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rdata;
      r_rresp <= w_rerr ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign s00_axi_rdata = r_rdata;
  assign s00_axi_rresp = r_rresp;

`ifdef MMIO_IRQ_EN
  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, ro_d,
                      s00_axi_araddr[OFF-1:0], w_cmt_addr[OFF-1:0]};
`else
  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, ro_d, irq_in,
                      s00_axi_araddr[OFF-1:0], w_cmt_addr[OFF-1:0]};
`endif

endmodule

// File: tb/tb_mmio_regfile_axil.sv
// Directed bench for mmio_regfile_axil (32-bit data, 12-bit address).
// Covers both builds; IRQ checks follow `MMIO_IRQ_EN.
module tb_mmio_regfile_axil;

  localparam logic [255:0] RST_V = {32'h1234_5678, 224'h0};

  logic         clk = 1'b0;
  logic         areset;
  logic [11:0]  awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [11:0]  araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [255:0] reg_q;
  logic [7:0]   reg_wr_pulse;
  logic [255:0] ro_d;
  logic [3:0]   irq_in;
  logic         irq;

  int           n_chk = 0;
  int           n_err = 0;
  int           pulse_cnt = 0;
  int           p0;
  logic [255:0] exp_q;
  logic [1:0]   rsp;
  logic [31:0]  rd;

  always #5 clk = ~clk;

  always @(posedge clk) pulse_cnt <= pulse_cnt + $countones(reg_wr_pulse);

  mmio_regfile_axil #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (12),
    .NUM_REGS   (8),
    .RO_MASK    (8'h04),
    .RST_VAL    (RST_V),
    .NUM_IRQ    (4)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (areset),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .reg_q           (reg_q),
    .reg_wr_pulse    (reg_wr_pulse),
    .ro_d            (ro_d),
    .irq_in          (irq_in),
    .irq             (irq)
  );

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int   n;
    logic aw_acc;
    logic w_acc;
    @(negedge clk);
    awaddr  = a;
    awvalid = 1'b1;
    wdata   = d;
    wstrb   = s;
    wvalid  = 1'b1;
    bready  = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 16) begin
      aw_acc = awready;
      w_acc  = wready;
      @(negedge clk);
      if (aw_acc) awvalid = 1'b0;
      if (w_acc) wvalid = 1'b0;
      n++;
    end
    chk("wr_hs", {awvalid, wvalid}, 0);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    n = 0;
    while (!bvalid && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("wr_bvalid", bvalid, 1);
    resp = bresp;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    int   n;
    logic ar_acc;
    @(negedge clk);
    araddr  = a;
    arvalid = 1'b1;
    rready  = 1'b1;
    n = 0;
    while (arvalid && n < 16) begin
      ar_acc = arready;
      @(negedge clk);
      if (ar_acc) arvalid = 1'b0;
      n++;
    end
    chk("rd_hs", arvalid, 0);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("rd_rvalid", rvalid, 1);
    d    = rdata;
    resp = rresp;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    areset  = 1'b1;
    awaddr  = '0;
    awprot  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wvalid  = 1'b0;
    bready  = 1'b1;
    araddr  = '0;
    arprot  = '0;
    arvalid = 1'b0;
    rready  = 1'b1;
    irq_in  = '0;
    ro_d    = {8{32'hFFFF_0000}};
    ro_d[64 +: 32] = 32'hA5A5_A5A5;
    exp_q   = RST_V;

    repeat (3) @(negedge clk);
    chk("rst_ready", {awready, wready, arready}, 0);
    chk("rst_valid", {bvalid, rvalid}, 0);
    chk("rst_resp", {bresp, rresp, rdata}, 0);
    chk("rst_pulse", reg_wr_pulse, 0);
    chk("rst_regq", reg_q, RST_V);
    chk("rst_irq", irq, 0);
    areset = 1'b0;
    @(negedge clk);
    chk("idle_ready", {awready, wready, arready}, 3'b111);

    // Basic writes; slot 2 is read-only.
    axi_write(12'h000, 32'd1, 4'hF, rsp);
    chk("w0_resp", rsp, 2'b00);
    axi_write(12'h004, 32'd2, 4'hF, rsp);
    chk("w1_resp", rsp, 2'b00);
    p0 = pulse_cnt;
    axi_write(12'h008, 32'd3, 4'hF, rsp);
    chk("w2_ro_resp", rsp, 2'b10);
    chk("w2_ro_pulse", pulse_cnt - p0, 0);
    axi_write(12'h00C, 32'd4, 4'hF, rsp);
    chk("w3_resp", rsp, 2'b00);
    exp_q[0 +: 32]  = 32'd1;
    exp_q[32 +: 32] = 32'd2;
    exp_q[96 +: 32] = 32'd4;
    chk("regq_basic", reg_q, exp_q);

    axi_read(12'h000, rd, rsp);
    chk("r0", {rsp, rd}, {2'b00, 32'd1});
    axi_read(12'h004, rd, rsp);
    chk("r1", {rsp, rd}, {2'b00, 32'd2});
    axi_read(12'h008, rd, rsp);
    chk("r2_ro", {rsp, rd}, {2'b00, 32'hA5A5_A5A5});
    axi_read(12'h00C, rd, rsp);
    chk("r3", {rsp, rd}, {2'b00, 32'd4});

    // AW first, W three cycles later, low half-word strobe.
    p0 = pulse_cnt;
    @(negedge clk);
    awaddr  = 12'h004;
    awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("split_rdy", {awready, wready}, 2'b01);
    @(negedge clk);
    @(negedge clk);
    wdata  = 32'hDEAD_BEEF;
    wstrb  = 4'b0011;
    wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("split_bv0", {bvalid, reg_wr_pulse}, 0);
    @(negedge clk);
    chk("split_bv1", bvalid, 1);
    chk("split_pulse", reg_wr_pulse, 8'h02);
    chk("split_bresp", bresp, 2'b00);
    exp_q[32 +: 32] = 32'h0000_BEEF;
    chk("split_regq", reg_q, exp_q);
    @(negedge clk);
    chk("split_end", {bvalid, reg_wr_pulse}, 0);
    chk("split_pcnt", pulse_cnt - p0, 1);

    // Zero strobe, out-of-range.
    p0 = pulse_cnt;
    axi_write(12'h000, 32'hFFFF_FFFF, 4'h0, rsp);
    chk("wstrb0_resp", rsp, 2'b00);
    axi_write(12'h100, 32'hFFFF_FFFF, 4'hF, rsp);
    chk("oor_wresp", rsp, 2'b10);
    chk("oor_pulse", pulse_cnt - p0, 0);
    chk("oor_regq", reg_q, exp_q);
    axi_read(12'h100, rd, rsp);
    chk("oor_read", {rsp, rd}, {2'b10, 32'd0});

    // Read captured on the commit edge of a write to the same reg.
    @(negedge clk);
    awaddr  = 12'h000;
    wdata   = 32'h55;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    araddr  = 12'h000;
    arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("rw_same_valid", {bvalid, rvalid}, 2'b11);
    chk("rw_same_old", rdata, 32'd1);
    @(negedge clk);
    exp_q[0 +: 32] = 32'h55;
    axi_read(12'h000, rd, rsp);
    chk("rw_same_new", rd, 32'h55);

    // B stall with a second AW pending.
    @(negedge clk);
    bready  = 1'b0;
    awaddr  = 12'h00C;
    wdata   = 32'h33;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    @(negedge clk);
    awaddr  = 12'h010;
    awvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bstall", {bvalid, bresp, awready}, {1'b1, 2'b00, 1'b0});
    end
    awvalid = 1'b0;
    bready  = 1'b1;
    @(negedge clk);
    chk("bstall_end", {bvalid, awready}, 2'b01);
    exp_q[96 +: 32] = 32'h33;
    chk("bstall_regq", reg_q, exp_q);

    // R stall with a second AR pending.
    @(negedge clk);
    rready  = 1'b0;
    araddr  = 12'h004;
    arvalid = 1'b1;
    @(negedge clk);
    araddr  = 12'h100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rstall", {rvalid, rresp, rdata, arready},
          {1'b1, 2'b00, 32'h0000_BEEF, 1'b0});
    end
    arvalid = 1'b0;
    rready  = 1'b1;
    @(negedge clk);
    chk("rstall_end", {rvalid, arready}, 2'b01);

`ifdef MMIO_IRQ_EN
    axi_write(12'h024, 32'h1, 4'hF, rsp);
    chk("irq_en_resp", rsp, 2'b00);
    chk("irq_idle", irq, 0);
    @(negedge clk);
    irq_in = 4'h1;
    @(negedge clk);
    irq_in = 4'h0;
    chk("irq_set", irq, 1);
    axi_read(12'h020, rd, rsp);
    chk("irq_pend_rd", {rsp, rd}, {2'b00, 32'h1});
    axi_write(12'h020, 32'h1, 4'hF, rsp);
    chk("irq_clr_resp", rsp, 2'b00);
    chk("irq_clr", irq, 0);
    axi_read(12'h020, rd, rsp);
    chk("irq_pend_clr", {rsp, rd}, {2'b00, 32'h0});
`else
    axi_read(12'h020, rd, rsp);
    chk("noirq_rd", {rsp, rd}, {2'b10, 32'd0});
    axi_write(12'h024, 32'h1, 4'hF, rsp);
    chk("noirq_wr", rsp, 2'b10);
    @(negedge clk);
    irq_in = 4'hF;
    @(negedge clk);
    irq_in = 4'h0;
    chk("noirq_irq", irq, 0);
`endif

    // Reset lands on what would have been the commit edge.
    @(negedge clk);
    awaddr  = 12'h000;
    wdata   = 32'hFFFF;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    areset  = 1'b1;
    @(negedge clk);
    chk("mid_rst_regq", reg_q, RST_V);
    chk("mid_rst_out", {awready, wready, arready, bvalid, rvalid},
        0);
    chk("mid_rst_data", {bresp, rresp, rdata, reg_wr_pulse, irq}, 0);
    areset = 1'b0;
    @(negedge clk);
    chk("post_rst", {awready, wready, arready, bvalid}, 4'b1110);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
